muldiv_hilo: RTL

- Multi-cycle integer multiply/divide unit with the architectural HI/LO registers for the MIPS datapath.
- Sits directly downstream of the register file. It consumes the two register read ports (rs/rt values) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Its hi/lo outputs feed the writeback mux for MFHI/MFLO.
- It exposes busy so the control unit stalls MFHI/MFLO and further mul/div issues until the result is ready.

---
 rtl/muldiv_hilo_if.sv | 20 ++
 rtl/muldiv_hilo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_if.sv
// Issue/result bundle between the register-file read ports, the mul/div unit and writeback.
interface muldiv_hilo_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] rs_val;
   logic [WIDTH-1:0] rt_val;
   logic             mthi;
   logic             mtlo;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (output start, op, rs_val, rt_val, mthi, mtlo,
                    input  busy, done, hi, lo);
   modport slave  (input  start, op, rs_val, rt_val, mthi, mtlo,
                    output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_hilo.sv
// Multi-cycle MIPS multiply/divide unit with architectural HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN ends multiplies once the remaining multiplier bits are zero.
module muldiv_hilo #(
   parameter int WIDTH = 32
) (
   input logic          clk,
   input logic          rst,
   muldiv_hilo_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     is_div_q, is_div_d;
   logic                     neg_res_q, neg_res_d;
   logic                     neg_rem_q, neg_rem_d;
   logic [2*WIDTH-1:0]       mcand_q, mcand_d;
   logic [2*WIDTH-1:0]       acc_q, acc_d;
   logic [WIDTH-1:0]         b_q, b_d;
   logic [WIDTH-1:0]         dvsr_q, dvsr_d;
   logic [WIDTH-1:0]         rs_q, rs_d;
   logic [WIDTH-1:0]         hi_q, hi_d;
   logic [WIDTH-1:0]         lo_q, lo_d;
   logic                     done_q, done_d;

   logic                     rs_neg, rt_neg;
   logic [WIDTH-1:0]         rs_mag, rt_mag;
   logic [WIDTH:0]           trial;
   logic [2*WIDTH-1:0]       prod;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         is_div_q  <= 1'b0;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         mcand_q   <= '0;
         acc_q     <= '0;
         b_q       <= '0;
         dvsr_q    <= '0;
         rs_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         is_div_q  <= is_div_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         mcand_q   <= mcand_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         dvsr_q    <= dvsr_d;
         rs_q      <= rs_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      is_div_d  = is_div_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      mcand_d   = mcand_q;
      acc_d     = acc_q;
      b_d       = b_q;
      dvsr_d    = dvsr_q;
      rs_d      = rs_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      rs_neg    = ~bus.op[0] & bus.rs_val[WIDTH-1];
      rt_neg    = ~bus.op[0] & bus.rt_val[WIDTH-1];
      rs_mag    = magnitude(bus.rs_val, rs_neg);
      rt_mag    = magnitude(bus.rt_val, rt_neg);
      trial     = {acc_q[WIDTH-1:0], b_q[WIDTH-1]} - {1'b0, dvsr_q};
      prod      = neg_res_q ? -acc_q : acc_q;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d   = RUN;
               cnt_d     = '0;
               is_div_d  = bus.op[1];
               neg_res_d = rs_neg ^ rt_neg;
               neg_rem_d = rs_neg;
               acc_d     = '0;
               mcand_d   = {{WIDTH{1'b0}}, rs_mag};
               b_d       = bus.op[1] ? rs_mag : rt_mag;
               dvsr_d    = rt_mag;
               rs_d      = bus.rs_val;
            end else begin
               if (bus.mthi) hi_d = bus.rs_val;
               if (bus.mtlo) lo_d = bus.rs_val;
            end
         end
         RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (!is_div_q) begin
               if (b_q[0]) acc_d = acc_q + mcand_q;
               mcand_d = mcand_q << 1;
               b_d     = b_q >> 1;
            end else if (!trial[WIDTH]) begin
               // Restoring divide: keep the subtraction only when it did not borrow.
               acc_d = {{WIDTH{1'b0}}, trial[WIDTH-1:0]};
               b_d   = {b_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {{WIDTH{1'b0}}, acc_q[WIDTH-2:0], b_q[WIDTH-1]};
               b_d   = {b_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == CW'(WIDTH-1)) begin
               state_d = FIN;
            end
`ifdef MULDIV_EARLY_OUT_EN
            else if (!is_div_q && b_d == '0) begin
               state_d = FIN;
            end
`endif
         end
         FIN: begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (!is_div_q) begin
               hi_d = prod[2*WIDTH-1:WIDTH];
               lo_d = prod[WIDTH-1:0];
            end else if (dvsr_q == '0) begin
               hi_d = rs_q;
               lo_d = '1;
            end else begin
               // Quotient sign from operand signs; remainder follows the dividend.
               hi_d = magnitude(acc_q[WIDTH-1:0], neg_rem_q);
               lo_d = magnitude(b_q, neg_res_q);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.busy = (state_q != IDLE);
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;
endmodule
